// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Moore control FSM for a multi-cycle RV32 subset core.
//               Sequences fetch, decode, memory, ALU, branch and jal steps
//               and drives the datapath write enables and mux selects.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm #(
    parameter int USE_MEM_READY = 1
) (
    input  logic        clk,
    input  logic        srst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    input  logic        negative,
    input  logic        carry,
    input  logic        over_flow,
    output logic        pc_w,
    output logic        ir_w,
    output logic        mem_w,
    output logic        reg_w,
    output logic        adr_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [1:0]  imm_src,
    output logic [2:0]  alu_control,
    output logic        illegal,
    output logic [3:0]  state
);

    // State encoding (FETCH must stay 4'd0: it is the visible reset value)
    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECUTER = 4'd6;
    localparam logic [3:0] c_EXECUTEI = 4'd7;
    localparam logic [3:0] c_ALUWB    = 4'd8;
    localparam logic [3:0] c_BRANCH   = 4'd9;
    localparam logic [3:0] c_JAL      = 4'd10;

    // Opcodes
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    // ALU operations
    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_XOR = 3'b100;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_ready;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused;

    logic [3:0] w_dec_next;
    logic       w_dec_bad;
    logic       w_taken;
    logic [2:0] w_alu_op;

    logic       w_pc_w;
    logic       w_ir_w;
    logic       w_mem_w;
    logic       w_reg_w;
    logic       w_illegal;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    // Register/immediate fields belong to the datapath, not to control
    assign w_unused = ^{instr[24:15], instr[11:7]};

    // With the handshake disabled every memory access completes immediately
    generate
        if (USE_MEM_READY != 0) begin : g_use_ready
            assign w_ready = mem_ready;
        end else begin : g_no_ready
            logic w_unused_ready;
            assign w_unused_ready = mem_ready;
            assign w_ready        = 1'b1;
        end
    endgenerate

    // Instruction legality check and DECODE successor state
    always_comb begin
        w_dec_bad  = 1'b0;
        w_dec_next = c_FETCH;
        case (w_opcode)
            c_OP_LOAD, c_OP_STORE: begin
                if (w_funct3 != 3'b010) w_dec_bad = 1'b1;
                else                    w_dec_next = c_MEMADR;
            end
            c_OP_R: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b011 || w_funct3 == 3'b101)
                    w_dec_bad = 1'b1;
                else if (!(w_funct7 == 7'b0000000 ||
                           (w_funct7 == 7'b0100000 && w_funct3 == 3'b000)))
                    w_dec_bad = 1'b1;
                else
                    w_dec_next = c_EXECUTER;
            end
            c_OP_I: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b011 || w_funct3 == 3'b101)
                    w_dec_bad = 1'b1;
                else
                    w_dec_next = c_EXECUTEI;
            end
            c_OP_BRANCH: begin
                if (w_funct3 == 3'b010 || w_funct3 == 3'b011) w_dec_bad = 1'b1;
                else                                          w_dec_next = c_BRANCH;
            end
            c_OP_JAL: w_dec_next = c_JAL;
            default:  w_dec_bad  = 1'b1;
        endcase
        if (w_dec_bad) w_dec_next = c_FETCH;
    end

    // Branch condition from flags of rs1 - rs2 (carry means no borrow)
    always_comb begin
        case (w_funct3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = !zero;
            3'b100:  w_taken = negative ^ over_flow;
            3'b101:  w_taken = !(negative ^ over_flow);
            3'b110:  w_taken = !carry;
            3'b111:  w_taken = carry;
            default: w_taken = 1'b0;
        endcase
    end

    // ALU operation for R/I-type execute; funct7 only selects sub for R-type
    always_comb begin
        case (w_funct3)
            3'b000:  w_alu_op = (w_opcode == c_OP_R && w_funct7[5]) ? c_ALU_SUB : c_ALU_ADD;
            3'b010:  w_alu_op = c_ALU_SLT;
            3'b100:  w_alu_op = c_ALU_XOR;
            3'b110:  w_alu_op = c_ALU_OR;
            3'b111:  w_alu_op = c_ALU_AND;
            default: w_alu_op = c_ALU_ADD;
        endcase
    end

    // Per-state datapath controls and next-state selection
    always_comb begin
        w_next      = r_state;
        w_pc_w      = 1'b0;
        w_ir_w      = 1'b0;
        w_mem_w     = 1'b0;
        w_reg_w     = 1'b0;
        w_illegal   = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        imm_src     = 2'b00;
        alu_control = c_ALU_ADD;
        case (r_state)
            c_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                w_ir_w     = w_ready;
                w_pc_w     = w_ready;
                w_next     = w_ready ? c_DECODE : c_FETCH;
            end
            c_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
                w_illegal = w_dec_bad;
                w_next    = w_dec_next;
            end
            c_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (w_opcode == c_OP_STORE) ? 2'b01 : 2'b00;
                w_next    = (w_opcode == c_OP_STORE) ? c_MEMWRITE : c_MEMREAD;
            end
            c_MEMREAD: begin
                adr_src = 1'b1;
                w_next  = w_ready ? c_MEMWB : c_MEMREAD;
            end
            c_MEMWB: begin
                result_src = 2'b01;
                w_reg_w    = 1'b1;
                w_next     = c_FETCH;
            end
            c_MEMWRITE: begin
                adr_src = 1'b1;
                w_mem_w = 1'b1;
                w_next  = w_ready ? c_FETCH : c_MEMWRITE;
            end
            c_EXECUTER: begin
                alu_src_a   = 2'b10;
                alu_control = w_alu_op;
                w_next      = c_ALUWB;
            end
            c_EXECUTEI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = w_alu_op;
                w_next      = c_ALUWB;
            end
            c_ALUWB: begin
                w_reg_w = 1'b1;
                w_next  = c_FETCH;
            end
            c_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = c_ALU_SUB;
                imm_src     = 2'b10;
                w_pc_w      = w_taken;
                w_next      = c_FETCH;
            end
            c_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                imm_src   = 2'b11;
                w_pc_w    = 1'b1;
                w_next    = c_ALUWB;
            end
            default: w_next = c_FETCH;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!srst) r_state <= c_FETCH;
        else       r_state <= w_next;
    end

    // Writes and the debug state are forced quiet for as long as reset is low
    assign pc_w    = srst & w_pc_w;
    assign ir_w    = srst & w_ir_w;
    assign mem_w   = srst & w_mem_w;
    assign reg_w   = srst & w_reg_w;
    assign illegal = srst & w_illegal;
    assign state   = srst ? r_state : c_FETCH;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Directed cycle-by-cycle checks of mc_control_fsm outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        srst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        zero, negative, carry, over_flow;
    logic        pc_w, ir_w, mem_w, reg_w, adr_src, illegal;
    logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0]  alu_control;
    logic [3:0]  state;

    int errors = 0;
    int checks = 0;

    mc_control_fsm #(.USE_MEM_READY(1)) dut (
        .clk         (clk),
        .srst        (srst),
        .instr       (instr),
        .mem_ready   (mem_ready),
        .zero        (zero),
        .negative    (negative),
        .carry       (carry),
        .over_flow   (over_flow),
        .pc_w        (pc_w),
        .ir_w        (ir_w),
        .mem_w       (mem_w),
        .reg_w       (reg_w),
        .adr_src     (adr_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .illegal     (illegal),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compare every output against one expected cycle, then advance a clock.
    // Packed order: pc ir mem reg adr a b res imm alu ill state
    task automatic cyc(input string tag,
                       input logic pcw, input logic irw, input logic memw, input logic regw,
                       input logic adr, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] rs, input logic [1:0] imm, input logic [2:0] alu,
                       input logic ill, input logic [3:0] st);
        logic [31:0] got, exp;
        #1;
        got = {11'd0, pc_w, ir_w, mem_w, reg_w, adr_src, alu_src_a, alu_src_b,
               result_src, imm_src, alu_control, illegal, state};
        exp = {11'd0, pcw, irw, memw, regw, adr, a, b, rs, imm, alu, ill, st};
        chk(tag, got, exp);
        @(posedge clk);
        #1;
    endtask

    // Common first two cycles of every instruction (mem_ready=1)
    task automatic fetch_decode(input string tag);
        cyc({tag, ".fetch"},  1,1,0,0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0, 4'd0);
        cyc({tag, ".decode"}, 0,0,0,0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000, 0, 4'd1);
    endtask

    task automatic branch_case(input string tag, input logic [31:0] ins,
                               input logic z, input logic n, input logic c, input logic v,
                               input logic taken);
        instr = ins; zero = z; negative = n; carry = c; over_flow = v;
        fetch_decode(tag);
        cyc({tag, ".branch"}, taken,0,0,0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 3'b001, 0, 4'd9);
        zero = 0; negative = 0; carry = 0; over_flow = 0;
    endtask

    initial begin
        srst = 0; instr = 32'h0; mem_ready = 1;
        zero = 0; negative = 0; carry = 0; over_flow = 0;
        @(posedge clk); #1;
        // Held in reset: FETCH selects visible, all writes quiet, even with mem_ready=1
        cyc("reset0", 0,0,0,0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0, 4'd0);
        cyc("reset1", 0,0,0,0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0, 4'd0);
        srst = 1;

        // add x3,x1,x2
        instr = 32'h002081B3;
        fetch_decode("add");
        cyc("add.exec",  0,0,0,0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'd6);
        cyc("add.aluwb", 0,0,0,1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'd8);

        // sub x3,x1,x2 (funct7 bit 5 selects sub)
        instr = 32'h402081B3;
        fetch_decode("sub");
        cyc("sub.exec",  0,0,0,0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 0, 4'd6);
        cyc("sub.aluwb", 0,0,0,1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'd8);

        // xori x1,x1,4
        instr = 32'h0040C093;
        fetch_decode("xori");
        cyc("xori.exec",  0,0,0,0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b100, 0, 4'd7);
        cyc("xori.aluwb", 0,0,0,1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'd8);

        // Fetch stall: one extra cycle per mem_ready=0
        mem_ready = 0;
        cyc("fetch.stall", 0,0,0,0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0, 4'd0);
        mem_ready = 1;

        // lw x5,8(x0) with three wait cycles in MEMREAD: 8 cycles total
        instr = 32'h00802283;
        fetch_decode("lw");
        cyc("lw.memadr", 0,0,0,0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 0, 4'd2);
        mem_ready = 0;
        for (int i = 0; i < 3; i++)
            cyc("lw.memrd.wait", 0,0,0,0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'd3);
        mem_ready = 1;
        cyc("lw.memrd",  0,0,0,0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'd3);
        cyc("lw.memwb",  0,0,0,1, 0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 0, 4'd4);

        // Branches
        branch_case("beq",  32'h00208463, 1, 0, 0, 0, 1);
        branch_case("bne",  32'h00209463, 1, 0, 0, 0, 0);
        branch_case("blt",  32'h0020C463, 0, 1, 0, 1, 0);
        branch_case("bge",  32'h0020D463, 0, 1, 0, 0, 0);
        branch_case("bltu", 32'h0020E463, 0, 0, 0, 0, 1);
        branch_case("bgeu", 32'h0020F463, 0, 0, 1, 0, 1);

        // jal x1,8
        instr = 32'h008000EF;
        fetch_decode("jal");
        cyc("jal.jal",   1,0,0,0, 0, 2'b01, 2'b10, 2'b00, 2'b11, 3'b000, 0, 4'd10);
        cyc("jal.aluwb", 0,0,0,1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'd8);

        // Unknown opcode: illegal pulse in DECODE, back to FETCH
        instr = 32'h0000007F;
        cyc("ill.fetch",  1,1,0,0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0, 4'd0);
        cyc("ill.decode", 0,0,0,0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000, 1, 4'd1);
        // R-type with funct7=0100000 but funct3=100 is also illegal
        instr = 32'h4020C1B3;
        cyc("ill2.fetch",  1,1,0,0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0, 4'd0);
        cyc("ill2.decode", 0,0,0,0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000, 1, 4'd1);
        // Load with funct3 other than 010 is illegal
        instr = 32'h00801283;
        cyc("ill3.fetch",  1,1,0,0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0, 4'd0);
        cyc("ill3.decode", 0,0,0,0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000, 1, 4'd1);

        // sw stalled in MEMWRITE, then reset mid-stall
        instr = 32'h0050A423;
        fetch_decode("sw");
        cyc("sw.memadr", 0,0,0,0, 0, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000, 0, 4'd2);
        mem_ready = 0;
        cyc("sw.memwr.wait0", 0,0,1,0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'd5);
        cyc("sw.memwr.wait1", 0,0,1,0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'd5);
        srst = 0; mem_ready = 1;
        cyc("sw.rst.inwr",  0,0,0,0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'd0);
        cyc("sw.rst.fetch", 0,0,0,0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0, 4'd0);
        srst = 1;
        instr = 32'h002081B3;
        fetch_decode("resume");
        cyc("resume.exec", 0,0,0,0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'd6);

        // Store without stall: back to FETCH after one MEMWRITE cycle
        instr = 32'h0050A423;
        cyc("resume.aluwb", 0,0,0,1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'd8);
        fetch_decode("sw2");
        cyc("sw2.memadr", 0,0,0,0, 0, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000, 0, 4'd2);
        cyc("sw2.memwr",  0,0,1,0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'd5);
        cyc("sw2.next",   1,1,0,0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
